// File: rtl/led_scan.sv
// rtl/led_scan.sv - binary-to-BCD converter with multiplexed 4-digit LED scan
//
// Purpose:
//   Converts a 16-bit unsigned value to four BCD digits by double-dabble.
//   Values above 9999 are clamped to 9999 and flagged on ovf. The digits are
//   time-multiplexed onto one BCD bus with active-low digit enables, and
//   leading zeros are blanked.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   value  in  16  unsigned binary value to display
//   load   in   1  one-cycle conversion request, ignored while busy
//   busy   out  1  conversion in progress
//   ovf    out  1  last accepted value exceeded 9999
//   num    out  4  BCD digit for the 7-segment decoder (0 when blanked)
//   an     out  4  active-low digit enables (all high when blanked)
//   blank  out  1  current digit is a suppressed leading zero
module led_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  num,
  output logic [3:0]  an,
  output logic        blank
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [15:0] MAX_VAL  = 16'd9999;
  localparam logic [15:0] SCAN_MAX = 16'(SCAN_DIV - 1);

  state_t      state_q;
  logic [15:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  bit_cnt_q;
  logic        ovf_pend_q;
  logic        busy_q;
  logic        ovf_q;
  logic [15:0] disp_q;

  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  idx_q, idx_d;

  logic [15:0] bcd_adj;
  logic [3:0]  cur_digit;
  logic        upper_zero;

  // Double-dabble correction: any nibble >= 5 would become >= 10 after the
  // shift, so pre-add 3 to carry it into the next decade.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM. The clamp to 9999 keeps every result nibble a valid
  // decimal digit and guarantees nothing shifts out of the top nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q      <= (value > MAX_VAL) ? MAX_VAL : value;
            ovf_pend_q <= (value > MAX_VAL);
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q     <= {bcd_adj[14:0], bin_q[15]};
          bin_q     <= {bin_q[14:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          disp_q  <= bcd_q;
          ovf_q   <= ovf_pend_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Free-running digit scan, independent of the converter.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    idx_d      = idx_q;
    if (scan_cnt_q >= SCAN_MAX) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // A digit is a leading zero when it and every more significant digit are
  // zero; digit 0 always shows so that a value of 0 still displays "0".
  always_comb begin
    upper_zero = 1'b0;
    case (idx_q)
      2'd1: upper_zero = (disp_q[15:4]  == 12'd0);
      2'd2: upper_zero = (disp_q[15:8]  == 8'd0);
      2'd3: upper_zero = (disp_q[15:12] == 4'd0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];
  assign blank     = upper_zero;
  assign num       = upper_zero ? 4'd0 : cur_digit;
  assign an        = upper_zero ? 4'b1111 : ~(4'b0001 << idx_q);
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_led_scan.sv
// tb/tb_led_scan.sv - scoreboard testbench for led_scan
module tb_led_scan;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        busy;
  logic        ovf;
  logic [3:0]  num;
  logic [3:0]  an;
  logic        blank;

  led_scan #(.SCAN_DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .ovf   (ovf),
    .num   (num),
    .an    (an),
    .blank (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: independent model of the scan position and displayed value,
  // compared every cycle; completed conversions pop the scoreboard.
  logic        started, prev_busy, r;
  int          blen, scnt, si;
  logic [1:0]  sidx;
  logic [15:0] mdisp;
  logic        movf;
  logic        eb;
  logic [3:0]  ea, en;
  exp_t        e;

  initial begin
    started = 0; prev_busy = 0; blen = 0; scnt = 0; sidx = 0; mdisp = 0; movf = 0;
    forever begin
      @(posedge clk);
      r = rst;
      if (r) begin
        started = 1; sidx = 0; scnt = 0; mdisp = 0; movf = 0;
      end else if (scnt == DIV - 1) begin
        scnt = 0; sidx = sidx + 2'd1;
      end else begin
        scnt++;
      end
      @(negedge clk);
      if (started) begin
        if (busy === 1'b1) blen++;
        if (r) begin
          chk("busy_in_rst", {31'd0, busy}, 32'd0);
          if (prev_busy && sb.size() > 0) void'(sb.pop_front());
          blen = 0;
        end else if (prev_busy && busy === 1'b0) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("busy_len", blen, 17);
            mdisp = e.bcd;
            movf  = e.ovf;
          end
          blen = 0;
        end
        si = int'(sidx);
        eb = (si != 0) && ((mdisp >> (4 * si)) == 16'd0);
        ea = eb ? 4'b1111 : ~(4'b0001 << si);
        en = eb ? 4'd0 : mdisp[4*si +: 4];
        chk("ovf", {31'd0, ovf}, {31'd0, movf});
        chk("an", {28'd0, an}, {28'd0, ea});
        chk("num", {28'd0, num}, {28'd0, en});
        chk("blank", {31'd0, blank}, {31'd0, eb});
        prev_busy = busy;
      end
    end
  end

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
  endtask

  task automatic convert(input logic [15:0] v, input logic [15:0] bcd, input logic o);
    sb.push_back('{bcd: bcd, ovf: o});
    pulse_load(v);
    wait_done();
    repeat (20) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] v;
    logic [15:0] bcd;
    logic        o;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd65535, 16'h9999, 1'b1};
    vecs[2] = '{16'd7,     16'h0007, 1'b0};
    vecs[3] = '{16'd0,     16'h0000, 1'b0};
    vecs[4] = '{16'd9999,  16'h9999, 1'b0};
    vecs[5] = '{16'd10000, 16'h9999, 1'b1};

    rst = 1'b1; load = 1'b0; value = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      convert(vecs[i].v, vecs[i].bcd, vecs[i].o);
    end

    // Load while busy must be ignored: 1234 completes, 42 never appears.
    sb.push_back('{bcd: 16'h1234, ovf: 1'b0});
    pulse_load(16'd1234);
    repeat (4) @(posedge clk);
    #1;
    pulse_load(16'd42);
    wait_done();
    repeat (20) @(posedge clk);
    #1;

    // Show 42 first so the abort below is distinguishable from a stale display.
    convert(16'd42, 16'h0042, 1'b0);

    // Abort: reset in mid-conversion clears the display, no later update.
    sb.push_back('{bcd: 16'h1234, ovf: 1'b0});
    pulse_load(16'd1234);
    repeat (4) @(posedge clk);
    #1;
    pulse_load(16'd42);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
